// File: rtl/ddr_frame_reader.sv
// Avalon-MM burst-read master: streams one frame line per line_request from the last completed DDR buffer.
// Latency: readdata to pix_data/pix_valid is one registered stage; bursts are issued back-to-back.
// Backpressure: holds address/read under waitrequest; caps in-flight bursts at MAX_OUTSTANDING.
module ddr_frame_reader #(
    parameter int ADDR_W          = 30,
    parameter int DATA_W          = 32,
    parameter int PIX_W           = 24,
    parameter int H_WORDS         = 1280,
    parameter int V_LINES         = 720,
    parameter int BURST_LEN       = 80,
    parameter int BCNT_W          = 8,
    parameter int LINE_STRIDE     = 1280,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk_100,
    input  logic              reset,
    input  logic              done_write_frame,
    input  logic              frame_start,
    input  logic              line_request,
    input  logic [ADDR_W-1:0] buf_base0,
    input  logic [ADDR_W-1:0] buf_base1,
    output logic              frame_buffer_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              line_done,
    output logic              frame_done,
    output logic              line_overrun,
    output logic              busy,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [BCNT_W-1:0] avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int NBURST = H_WORDS / BURST_LEN;
    localparam int BIDX_W = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam int LIDX_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int WCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LWC_W  = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_LINE, ISSUE, DRAIN} state_t;

    state_t             state, state_nxt;
    logic               wr_sel, last_sel;
    logic [ADDR_W-1:0]  line_addr, burst_addr;
    logic [LIDX_W-1:0]  line_idx;
    logic [BIDX_W-1:0]  burst_idx;
    logic               line_req_pend;
    logic [3:0]         outstanding;
    logic [WCNT_W-1:0]  word_cnt;
    logic [LWC_W-1:0]   line_word_cnt;
    logic               line_words_in;

    logic start_ok, issue_entry, accept, word_in;
    logic burst_last_word, line_last_word, last_burst, last_line, line_finished;

    assign start_ok        = (state == IDLE) && frame_start && frame_buffer_ready;
    assign issue_entry     = (state == WAIT_LINE) && line_req_pend;
    assign accept          = avm_read && !avm_waitrequest;
    // Returns seen in IDLE are leftovers from before a reset and must not move anything.
    assign word_in         = avm_readdatavalid && (state != IDLE);
    assign burst_last_word = word_in && (word_cnt == WCNT_W'(BURST_LEN - 1));
    assign line_last_word  = word_in && (line_word_cnt == LWC_W'(H_WORDS - 1));
    assign last_burst      = (burst_idx == BIDX_W'(NBURST - 1));
    assign last_line       = (line_idx == LIDX_W'(V_LINES - 1));
    assign line_finished   = (state == DRAIN) && (outstanding == 4'd0) && line_words_in;

    // Only outstanding can change while stalled, and only downwards, so read stays asserted.
    assign avm_read       = (state == ISSUE) && (outstanding < 4'(MAX_OUTSTANDING));
    assign avm_address    = burst_addr;
    assign avm_burstcount = BCNT_W'(BURST_LEN);

    generate
        if (DATA_W > PIX_W) begin : g_pad
            logic unused_readdata;
            assign unused_readdata = ^avm_readdata[DATA_W-1:PIX_W];
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start_ok) state_nxt = WAIT_LINE;
            WAIT_LINE: if (line_req_pend) state_nxt = ISSUE;
            ISSUE:     if (accept && last_burst) state_nxt = DRAIN;
            DRAIN:     if (line_finished) state_nxt = last_line ? IDLE : WAIT_LINE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state              <= IDLE;
            wr_sel             <= 1'b0;
            last_sel           <= 1'b0;
            frame_buffer_ready <= 1'b0;
            line_addr          <= '0;
            burst_addr         <= '0;
            line_idx           <= '0;
            burst_idx          <= '0;
            line_req_pend      <= 1'b0;
            outstanding        <= 4'd0;
            word_cnt           <= '0;
            line_word_cnt      <= '0;
            line_words_in      <= 1'b0;
            pix_data           <= '0;
            pix_valid          <= 1'b0;
            line_done          <= 1'b0;
            frame_done         <= 1'b0;
            line_overrun       <= 1'b0;
            busy               <= 1'b0;
        end else begin
            state        <= state_nxt;
            line_overrun <= 1'b0;

            if (done_write_frame) begin
                wr_sel             <= ~wr_sel;
                last_sel           <= wr_sel;
                frame_buffer_ready <= 1'b1;
            end

            // A buffer completing in the same cycle as frame_start is the one to read.
            if (start_ok) begin
                line_addr     <= ((done_write_frame ? wr_sel : last_sel) ? buf_base1 : buf_base0);
                line_idx      <= '0;
                busy          <= 1'b1;
                line_req_pend <= 1'b0;
            end else if (line_request && busy) begin
                if (line_req_pend && !issue_entry)
                    line_overrun <= 1'b1;
                else
                    line_req_pend <= 1'b1;
            end else if (issue_entry) begin
                line_req_pend <= 1'b0;
            end

            if (issue_entry) begin
                burst_idx  <= '0;
                burst_addr <= line_addr;
            end else if (accept) begin
                burst_idx  <= burst_idx + BIDX_W'(1);
                burst_addr <= burst_addr + ADDR_W'(BURST_LEN);
            end

            case ({accept, burst_last_word})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase

            if (word_in) begin
                word_cnt      <= (word_cnt == WCNT_W'(BURST_LEN - 1)) ? '0 : word_cnt + WCNT_W'(1);
                line_word_cnt <= line_last_word ? '0 : line_word_cnt + LWC_W'(1);
                pix_data      <= avm_readdata[PIX_W-1:0];
            end
            pix_valid  <= word_in;
            line_done  <= line_last_word;
            frame_done <= line_last_word && last_line;

            if (line_last_word)
                line_words_in <= 1'b1;
            else if (line_finished)
                line_words_in <= 1'b0;

            if (line_finished) begin
                if (last_line) begin
                    busy <= 1'b0;
                end else begin
                    line_idx  <= line_idx + LIDX_W'(1);
                    line_addr <= line_addr + ADDR_W'(LINE_STRIDE);
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_frame_reader.sv
// Randomised bench for ddr_frame_reader: burst-level memory model plus pixel scoreboard.
module tb_ddr_frame_reader;

    localparam int ADDR_W = 30, DATA_W = 32, PIX_W = 24, BCNT_W = 8;
    localparam int H = 16, BL = 4, V = 3, STRIDE = 32, MAXO = 2;

    logic clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    logic              reset, done_write_frame, frame_start, line_request;
    logic [ADDR_W-1:0] buf_base0, buf_base1;
    logic              frame_buffer_ready, pix_valid, line_done, frame_done, line_overrun, busy;
    logic [PIX_W-1:0]  pix_data;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [BCNT_W-1:0] avm_burstcount;
    logic              avm_waitrequest = 1'b0;
    logic [DATA_W-1:0] avm_readdata = '0;
    logic              avm_readdatavalid = 1'b0;

    ddr_frame_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIX_W(PIX_W), .H_WORDS(H), .V_LINES(V),
        .BURST_LEN(BL), .BCNT_W(BCNT_W), .LINE_STRIDE(STRIDE), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_100(clk_100), .reset(reset), .done_write_frame(done_write_frame),
        .frame_start(frame_start), .line_request(line_request),
        .buf_base0(buf_base0), .buf_base1(buf_base1),
        .frame_buffer_ready(frame_buffer_ready), .pix_data(pix_data), .pix_valid(pix_valid),
        .line_done(line_done), .frame_done(frame_done), .line_overrun(line_overrun), .busy(busy),
        .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] got);
        checks++;
        errors++;
        $display("FAIL %s: got %0h, expected nothing (t=%0t)", name, got, $time);
    endtask

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             ld;
        logic             fd;
    } exp_t;
    typedef struct {
        logic [ADDR_W-1:0] a;
        int                t;
    } word_t;

    exp_t              exp_q[$];
    logic [ADDR_W-1:0] burst_q[$];
    word_t             pend_q[$];
    logic [DATA_W-1:0] seed;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[15:0], ~a[15:0]} ^ seed;
    endfunction

    function automatic logic [PIX_W-1:0] exp_pix(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        d = mem_word(a);
        return d[PIX_W-1:0];
    endfunction

    // Memory model knobs (written by stimulus) and counters (written by the model).
    int lat = 2, stall_idx = -1, stall_len = 0, acc_base = 0, del_base = 0, stall_base = 0;
    bit rnd_wait = 1'b0;
    int cyc = 0, acc_cnt = 0, delivered = 0, stall_seen = 0;
    bit hold_prev = 1'b0;
    logic [ADDR_W-1:0] held_addr = '0;

    always @(negedge clk_100) begin
        logic  wr;
        word_t w;
        cyc++;
        wr = 1'b0;
        if (hold_prev) begin
            chk("hold_read", avm_read, 1);
            chk("hold_addr", avm_address, held_addr);
        end
        if (avm_read) begin
            if ((acc_cnt - acc_base) == stall_idx && (stall_seen - stall_base) < stall_len) begin
                wr = 1'b1;
                stall_seen++;
                chk("stall_addr", avm_address, burst_q[0]);
            end else if (rnd_wait && $urandom_range(0, 3) == 0) begin
                wr = 1'b1;
            end
            if (!wr) begin
                if (burst_q.size() == 0)
                    fail_now("burst_unexpected", avm_address);
                else
                    chk("burst_addr", avm_address, burst_q.pop_front());
                chk("inflight_limit",
                    ((acc_cnt - acc_base) - (delivered - del_base) / BL) < MAXO, 1);
                for (int i = 0; i < BL; i++)
                    pend_q.push_back(word_t'{a: avm_address + ADDR_W'(i), t: cyc + lat + i});
                acc_cnt++;
            end
        end
        hold_prev       = avm_read && wr;
        held_addr       = avm_address;
        avm_waitrequest = wr;
        if (pend_q.size() > 0 && pend_q[0].t <= cyc) begin
            w = pend_q.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = mem_word(w.a);
            delivered++;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
        end
    end

    int ld_cnt = 0, fd_cnt = 0, ovr_cnt = 0, pv_cnt = 0;
    bit busy_chk = 1'b0;

    always @(negedge clk_100) begin
        exp_t e;
        if (busy_chk) chk("busy_fall_after_frame_done", busy, 0);
        busy_chk = 1'b0;
        if (line_overrun) ovr_cnt++;
        if (pix_valid) begin
            pv_cnt++;
            if (exp_q.size() == 0) begin
                fail_now("pix_unexpected", pix_data);
            end else begin
                e = exp_q.pop_front();
                chk("pix_data", pix_data, e.pix);
                chk("line_done", line_done, e.ld);
                chk("frame_done", frame_done, e.fd);
            end
            if (line_done) ld_cnt++;
            if (frame_done) begin
                fd_cnt++;
                chk("busy_at_frame_done", busy, 1);
                busy_chk = 1'b1;
            end
        end else if (line_done || frame_done) begin
            fail_now("pulse_without_pix", {line_done, frame_done});
        end
    end

    int n_done = 0;

    task automatic tick();
        @(negedge clk_100);
    endtask

    task automatic pulse_line();
        line_request = 1'b1;
        tick();
        line_request = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] completed_base();
        return (n_done % 2 == 1) ? buf_base0 : buf_base1;
    endfunction

    task automatic load_expect(input logic [ADDR_W-1:0] base);
        for (int l = 0; l < V; l++) begin
            for (int w = 0; w < H; w++)
                exp_q.push_back(exp_t'{pix: exp_pix(base + ADDR_W'(l * STRIDE + w)),
                                       ld: (w == H - 1), fd: (w == H - 1 && l == V - 1)});
            for (int b = 0; b < H / BL; b++)
                burst_q.push_back(base + ADDR_W'(l * STRIDE + b * BL));
        end
    endtask

    task automatic wait_lines(input int target);
        int t = 0;
        while (ld_cnt < target && t < 2000) begin
            tick();
            t++;
        end
        chk("line_done_wait", ld_cnt >= target, 1);
    endtask

    task automatic run_frame(input int lat_i, input bit rw, input int st_idx, input int st_len,
                             input bit coincide, input bit ovr, input bit start_busy);
        int ld0, fd0, ovr0, pv0;
        lat = lat_i; rnd_wait = rw; stall_idx = st_idx; stall_len = st_len;
        acc_base = acc_cnt; del_base = delivered; stall_base = stall_seen;
        ld0 = ld_cnt; fd0 = fd_cnt; ovr0 = ovr_cnt; pv0 = pv_cnt;
        if (coincide) n_done++;
        load_expect(completed_base());
        done_write_frame = coincide;
        frame_start = 1'b1;
        tick();
        done_write_frame = 1'b0;
        frame_start = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
        chk("busy_after_start", busy, 1);
        for (int l = 0; l < V; l++) begin
            if (ovr && l == 1) begin
                repeat (3) tick();
                line_request = 1'b1;
                repeat (3) tick();
                line_request = 1'b0;
            end else if (!(ovr && l == 2)) begin
                if (l > 0) repeat ($urandom_range(0, 5)) tick();
                pulse_line();
            end
            if (start_busy && l == 0) begin
                tick();
                frame_start = 1'b1;
                tick();
                frame_start = 1'b0;
            end
            wait_lines(ld0 + l + 1);
        end
        repeat (3) tick();
        chk("frame_done_count", fd_cnt - fd0, 1);
        chk("line_done_count", ld_cnt - ld0, V);
        chk("pix_count", pv_cnt - pv0, H * V);
        chk("overrun_count", ovr_cnt - ovr0, ovr);
        chk("exp_pix_left", exp_q.size(), 0);
        chk("exp_burst_left", burst_q.size(), 0);
        chk("busy_end", busy, 0);
        if (st_len > 0) chk("stall_cycles", stall_seen - stall_base, st_len);
    endtask

    task automatic mid_reset();
        int t, pv0, d0;
        lat = 20; rnd_wait = 1'b0; stall_len = 0;
        acc_base = acc_cnt; del_base = delivered;
        load_expect(completed_base());
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        pulse_line();
        t = 0;
        while ((delivered - del_base) < 1 && t < 200) begin
            tick();
            t++;
        end
        chk("mid_reset_data_started", (delivered - del_base) >= 1, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        while (pend_q.size() > 3) void'(pend_q.pop_back());
        d0 = delivered;
        pv0 = pv_cnt;
        chk("rst_avm_read", avm_read, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fbr", frame_buffer_ready, 0);
        chk("rst_pix_valid", pix_valid, 0);
        exp_q.delete();
        burst_q.delete();
        n_done = 0;
        t = 0;
        while (pend_q.size() > 0 && t < 100) begin
            tick();
            t++;
        end
        repeat (3) tick();
        chk("stale_drained", pend_q.size(), 0);
        chk("stale_words_seen", (delivered - d0) >= 3, 1);
        chk("stale_no_pix", pv_cnt - pv0, 0);
        chk("stale_fbr", frame_buffer_ready, 0);
        chk("stale_busy", busy, 0);
    endtask

    initial begin
        int ovr0;
        reset = 1'b1; done_write_frame = 1'b0; frame_start = 1'b0; line_request = 1'b0;
        seed = $urandom;
        buf_base0 = ADDR_W'(32'h100);
        buf_base1 = ADDR_W'($urandom_range(1, 32'h3FFFF)) << 6;
        repeat (4) tick();
        chk("rst_pix_valid0", pix_valid, 0);
        chk("rst_pix_data0", pix_data, 0);
        chk("rst_line_done0", line_done, 0);
        chk("rst_frame_done0", frame_done, 0);
        chk("rst_overrun0", line_overrun, 0);
        chk("rst_busy0", busy, 0);
        chk("rst_fbr0", frame_buffer_ready, 0);
        chk("rst_avm_read0", avm_read, 0);
        chk("rst_avm_addr0", avm_address, 0);
        chk("burstcount", avm_burstcount, BL);
        reset = 1'b0;
        tick();

        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (2) tick();
        chk("start_not_ready_ignored", busy, 0);
        ovr0 = ovr_cnt;
        line_request = 1'b1;
        repeat (2) tick();
        line_request = 1'b0;
        repeat (2) tick();
        chk("idle_req_no_overrun", ovr_cnt - ovr0, 0);
        chk("idle_req_no_read", avm_read, 0);

        done_write_frame = 1'b1;
        tick();
        done_write_frame = 1'b0;
        n_done = 1;
        tick();
        chk("fbr_set", frame_buffer_ready, 1);

        run_frame(2, 1'b0, 1, 5, 1'b0, 1'b0, 1'b1);
        run_frame(20, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0);
        run_frame(2, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0);
        mid_reset();

        repeat (2) begin
            done_write_frame = 1'b1;
            tick();
            done_write_frame = 1'b0;
            n_done++;
            tick();
        end
        run_frame($urandom_range(1, 6), 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);
        run_frame(3, 1'b1, -1, 0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/ddr_frame_reader.md
Name: ddr_frame_reader

Overview:
Parametrised Avalon-MM burst-read master that streams frames from a DDR double buffer to the video output path, one line per line_request. It generalises the fixed 1280x720 / 80-word reader:
- geometry, burst length, line stride and data widths are parameters;
- up to MAX_OUTSTANDING bursts may be in flight;
- the Avalon read is held correctly under waitrequest;
- the buffer is swapped only at frame boundaries;
- line overruns and frame completion are reported.

Parameters:
ADDR_W, 30, Avalon word-address width
DATA_W, 32, Avalon readdata width
PIX_W, 24, output pixel width; pixel = readdata[PIX_W-1:0]
H_WORDS, 1280, words per line; must be a multiple of BURST_LEN
V_LINES, 720, lines per frame
BURST_LEN, 80, words per burst; must be at most 2^BCNT_W-1
BCNT_W, 8, burstcount width
LINE_STRIDE, 1280, address increment between lines, in words; must be >= H_WORDS
MAX_OUTSTANDING, 4, maximum issued-but-not-fully-returned bursts, 1..15

Ports:
clk_100  in  1  system clock
reset  in  1  synchronous, active-high reset
done_write_frame  in  1  writer finished a frame; one-cycle pulse
frame_start  in  1  start reading a new frame; one-cycle pulse
line_request  in  1  fetch the next line; one-cycle pulse
buf_base0  in  ADDR_W  base address of buffer 0
buf_base1  in  ADDR_W  base address of buffer 1
frame_buffer_ready  out  1  sticky; at least one complete frame has been written
pix_data  out  PIX_W  pixel data
pix_valid  out  1  pix_data qualifier
line_done  out  1  pulse when the last word of a line is output
frame_done  out  1  pulse when the last word of a frame is output
line_overrun  out  1  pulse when a line_request is dropped
busy  out  1  frame in progress
avm_address  out  ADDR_W  Avalon address
avm_read  out  1  Avalon read
avm_burstcount  out  BCNT_W  Avalon burstcount; constant BURST_LEN
avm_waitrequest  in  1  Avalon waitrequest
avm_readdata  in  DATA_W  Avalon read data
avm_readdatavalid  in  1  Avalon read data valid

Behaviour:
Reset and clocking:
- Single clock domain.
- reset is synchronous and active-high; it dominates every other input.
- All outputs reset to 0 except avm_burstcount, which is constant BURST_LEN.

Buffer selection:
- wr_sel resets to 0 and toggles on each done_write_frame.
- The last completed buffer is the one selected by the pre-toggle wr_sel value.
- frame_buffer_ready is set by the first done_write_frame and cleared only by reset.

Frame start:
- In IDLE, frame_start with frame_buffer_ready=1 latches base = completed buffer's address, sets line_idx=0, and moves to WAIT_LINE with busy=1.
- If done_write_frame and frame_start coincide, the buffer completed in that same cycle is used.
- frame_start while busy, or while frame_buffer_ready=0, is ignored.

States:
- IDLE: no Avalon activity.
- WAIT_LINE: idle until line_req_pend=1, then go to ISSUE with burst_idx=0 and line address = base + line_idx*LINE_STRIDE.
- ISSUE: assert avm_read with avm_address = line address + burst_idx*BURST_LEN.
  - A burst is accepted when avm_read=1 and avm_waitrequest=0.
  - While waitrequest=1, address and read are held stable.
  - The next burst is issued only when outstanding < MAX_OUTSTANDING; otherwise avm_read=0.
  - After burst H_WORDS/BURST_LEN-1 is accepted, go to DRAIN.
- DRAIN: wait until outstanding=0 and all line words have been output.
  - If line_idx=V_LINES-1: pulse frame_done and go to IDLE with busy=0.
  - Otherwise: increment line_idx and go to WAIT_LINE.

Line requests:
- line_req_pend is a single-entry flag.
  - Set by line_request while busy.
  - Cleared on entry to ISSUE.
- line_request arriving while line_req_pend=1 is dropped and pulses line_overrun.
- line_request in IDLE is ignored and does not pulse line_overrun.
- If line_request and the ISSUE entry coincide, the request is held pending for the next line.

Outstanding and word counters:
- outstanding is incremented on burst accept and decremented when a burst's final word (word_cnt=BURST_LEN-1) returns.
- If accept and completion coincide, outstanding is unchanged.
- word_cnt wraps at BURST_LEN; line_word_cnt wraps at H_WORDS.

Data path:
- pix_data <= avm_readdata[PIX_W-1:0] and pix_valid <= avm_readdatavalid, both registered, giving 1-cycle latency.
- readdatavalid seen in IDLE (stale data after reset) is discarded: pix_valid stays 0 and no counter moves.

Completion pulses:
- line_done is pulsed coincident with the pix_valid of the last word of the line.
- frame_done is pulsed coincident with line_done of the last line.

Reset mid-frame: everything returns to reset values in one cycle, and avm_read drops immediately.

Test Plan:
- Small configuration used throughout: H_WORDS=16, BURST_LEN=4, V_LINES=3, LINE_STRIDE=32, MAX_OUTSTANDING=2.
- Base 0x100, done_write_frame, then frame_start and 3 line_requests, zero-wait memory with 2-cycle read latency.
  - Bursts issued at 0x100, 0x104, 0x108, 0x10C; then 0x120 and up; then 0x140 and up.
  - 48 pix_valid pulses total; 3 line_done pulses; 1 frame_done pulse on the 48th word; busy falls the next cycle.
- avm_waitrequest held high for 5 cycles on the 2nd burst -> avm_address=0x104 and avm_read=1 stable for all 5 cycles; exactly one accept is counted.
- Memory latency of 20 cycles -> at most 2 bursts accepted before the first word returns; the 3rd burst is issued only after word 4 returns.
- Three line_requests in consecutive cycles during ISSUE -> one is held pending, one pulses line_overrun, and the next line starts correctly.
- Frame buffer selection:
  - done_write_frame twice (wr_sel back to 0), then frame_start -> reads buf_base1.
  - done_write_frame and frame_start in the same cycle -> uses the buffer that just completed.
- reset asserted mid-burst, with 3 stale readdatavalid afterwards -> avm_read=0 the next cycle; no pix_valid; frame_buffer_ready=0; a subsequent frame runs normally.
